// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: IDLE/RUN/DRAIN scan control, a registered pixel request stream,
// and HS/VS/blank outputs delayed PIX_LAT cycles to line up with a fixed-latency colour pipeline.
module vga_timing_gen #(
  parameter int   H_ACT   = 640,
  parameter int   H_FRONT = 16,
  parameter int   H_SYNC  = 96,
  parameter int   H_BACK  = 48,
  parameter int   V_ACT   = 480,
  parameter int   V_FRONT = 10,
  parameter int   V_SYNC  = 2,
  parameter int   V_BACK  = 33,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   PIX_LAT = 2,
  parameter int   CW      = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_abort,
  output logic          o_req_valid,
  output logic [CW-1:0] o_req_x,
  output logic [CW-1:0] o_req_y,
  output logic          o_VGA_HS,
  output logic          o_VGA_VS,
  output logic          o_VGA_blank,
  output logic          o_frame_start,
  output logic          o_busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_W  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_W  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_BEG = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_END = CW'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [CW-1:0] V_ACT_BEG = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_SYNC + V_BACK + V_ACT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cx, cy, cx_nxt, cy_nxt;
  logic          scanning, active;
  logic          hs_q, vs_q, blank_q;

  assign scanning = (state != IDLE);
  assign active   = scanning && (cx >= H_ACT_BEG) && (cx <= H_ACT_END)
                             && (cy >= V_ACT_BEG) && (cy <= V_ACT_END);

  // Abort overrides everything; a start while draining cancels the pending stop.
  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    if (scanning) begin
      if (cx == H_LAST) begin
        cx_nxt = '0;
        cy_nxt = (cy == V_LAST) ? '0 : cy + CW'(1);
      end else begin
        cx_nxt = cx + CW'(1);
      end
    end
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (i_stop) state_nxt = DRAIN;
      DRAIN: begin
        if (i_start)                           state_nxt = RUN;
        else if (cx == H_LAST && cy == V_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_abort) begin
      state_nxt = IDLE;
      cx_nxt    = '0;
      cy_nxt    = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cx            <= '0;
      cy            <= '0;
      o_busy        <= 1'b0;
      o_req_valid   <= 1'b0;
      o_req_x       <= '0;
      o_req_y       <= '0;
      o_frame_start <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cx            <= cx_nxt;
      cy            <= cy_nxt;
      o_busy        <= (state_nxt != IDLE);
      o_req_valid   <= active;
      o_req_x       <= active ? cx - H_ACT_BEG : '0;
      o_req_y       <= active ? cy - V_ACT_BEG : '0;
      o_frame_start <= active && (cx == H_ACT_BEG) && (cy == V_ACT_BEG);
      hs_q          <= (scanning && cx < H_SYNC_W) ? HS_POL : ~HS_POL;
      vs_q          <= (scanning && cy < V_SYNC_W) ? VS_POL : ~VS_POL;
      blank_q       <= active;
    end
  end

  generate
    if (PIX_LAT == 0) begin : g_no_delay
      assign o_VGA_HS    = hs_q;
      assign o_VGA_VS    = vs_q;
      assign o_VGA_blank = blank_q;
    end else begin : g_delay
      logic [PIX_LAT-1:0] hs_dl, vs_dl, blank_dl;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          hs_dl    <= {PIX_LAT{~HS_POL}};
          vs_dl    <= {PIX_LAT{~VS_POL}};
          blank_dl <= '0;
        end else begin
          hs_dl[0]    <= hs_q;
          vs_dl[0]    <= vs_q;
          blank_dl[0] <= blank_q;
          for (int i = 1; i < PIX_LAT; i++) begin
            hs_dl[i]    <= hs_dl[i-1];
            vs_dl[i]    <= vs_dl[i-1];
            blank_dl[i] <= blank_dl[i-1];
          end
        end
      end

      assign o_VGA_HS    = hs_dl[PIX_LAT-1];
      assign o_VGA_VS    = vs_dl[PIX_LAT-1];
      assign o_VGA_blank = blank_dl[PIX_LAT-1];
    end
  endgenerate

endmodule
